// File: rtl/mdu.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Define MDU_MADD_EN to add madd/maddu/msub/msubu (op 7..10).
module mdu #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic        start,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);
  // state | meaning
  // IDLE  | accepts new ops; mthi/mtlo write HI/LO directly
  // BUSY  | op in flight, cnt counts down to completion, all ops ignored

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MTHI  = 4'd5;
  localparam logic [3:0] OP_MTLO  = 4'd6;
`ifdef MDU_MADD_EN
  localparam logic [3:0] OP_MADD  = 4'd7;
  localparam logic [3:0] OP_MADDU = 4'd8;
  localparam logic [3:0] OP_MSUB  = 4'd9;
  localparam logic [3:0] OP_MSUBU = 4'd10;
`endif

  typedef enum logic {IDLE, BUSY} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;

  logic [63:0] prod_s, prod_u, res;
  logic        res_wr;
  logic [3:0]  len;
  logic        div_signed, neg_q, neg_r;
  logic [31:0] mag_a, mag_b, divisor, q_u, r_u;

`ifdef MDU_MADD_EN
  assign start = (op >= OP_MULT && op <= OP_DIVU) || (op >= OP_MADD && op <= OP_MSUBU);
`else
  assign start = (op >= OP_MULT && op <= OP_DIVU);
`endif

  // Divide on magnitudes so the 0x80000000 / -1 overflow case wraps cleanly.
  always_comb begin
    prod_s     = $signed({{32{A[31]}}, A}) * $signed({{32{B[31]}}, B});
    prod_u     = {32'd0, A} * {32'd0, B};
    div_signed = (op == OP_DIV);
    neg_q      = div_signed && (A[31] ^ B[31]);
    neg_r      = div_signed && A[31];
    mag_a      = (div_signed && A[31]) ? (32'd0 - A) : A;
    mag_b      = (div_signed && B[31]) ? (32'd0 - B) : B;
    divisor    = (B == 32'd0) ? 32'd1 : mag_b;
    q_u        = mag_a / divisor;
    r_u        = mag_a % divisor;
    res        = 64'd0;
    res_wr     = 1'b1;
    len        = 4'(MULT_CYCLES);
    case (op)
      OP_MULT:  res = prod_s;
      OP_MULTU: res = prod_u;
      OP_DIV, OP_DIVU: begin
        len    = 4'(DIV_CYCLES);
        res_wr = (B != 32'd0);
        res    = {neg_r ? (32'd0 - r_u) : r_u, neg_q ? (32'd0 - q_u) : q_u};
      end
`ifdef MDU_MADD_EN
      OP_MADD:  res = {HI, LO} + prod_s;
      OP_MADDU: res = {HI, LO} + prod_u;
      OP_MSUB:  res = {HI, LO} - prod_s;
      OP_MSUBU: res = {HI, LO} - prod_u;
`endif
      default:  res = 64'd0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      busy    <= 1'b0;
      HI      <= 32'd0;
      LO      <= 32'd0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      pend_wr <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            pend_hi <= res[63:32];
            pend_lo <= res[31:0];
            pend_wr <= res_wr;
            cnt     <= len;
            busy    <= 1'b1;
            state   <= BUSY;
          end else if (op == OP_MTHI) begin
            HI <= A;
          end else if (op == OP_MTLO) begin
            LO <= A;
          end
        end
        BUSY: begin
          if (cnt == 4'd1) begin
            if (pend_wr) begin
              HI <= pend_hi;
              LO <= pend_lo;
            end
            cnt   <= 4'd0;
            busy  <= 1'b0;
            state <= IDLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: vector table plus hand-written multi-cycle sequences.
module tb_mdu;
  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  op;
  logic [31:0] A, B;
  logic        start, busy;
  logic [31:0] HI, LO;

  int n_cmp = 0;
  int n_bad = 0;

  mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .op(op), .A(A), .B(B),
    .start(start), .busy(busy), .HI(HI), .LO(LO)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          cyc;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic exp_start(input logic [3:0] o);
`ifdef MDU_MADD_EN
    return (o >= 4'd1 && o <= 4'd4) || (o >= 4'd7 && o <= 4'd10);
`else
    return (o >= 4'd1 && o <= 4'd4);
`endif
  endfunction

  // Issues one op for one edge, then counts busy cycles and checks HI/LO hold until completion.
  task automatic run_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                        output int cyc, output logic held);
    logic [31:0] pre_hi, pre_lo;
    @(negedge clk);
    op = o; A = a; B = b;
    pre_hi = HI; pre_lo = LO;
    #1 check("start_issue", {31'd0, start}, {31'd0, exp_start(o)});
    @(posedge clk);
    #1 op = 4'd0;
    cyc  = 0;
    held = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (!busy) break;
      cyc++;
      if (HI !== pre_hi || LO !== pre_lo) held = 1'b0;
    end
  endtask

  task automatic move_to(input logic [3:0] o, input logic [31:0] a);
    @(negedge clk);
    op = o; A = a;
    @(posedge clk);
    #1 op = 4'd0;
  endtask

  initial begin
    int   cyc;
    logic held;

    vecs[0] = '{4'd1, 32'hFFFFFFFD, 32'd5,        32'hFFFFFFFF, 32'hFFFFFFF1, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFD, 32'd5,        32'h00000004, 32'hFFFFFFF1, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 10};
    vecs[4] = '{4'd4, 32'd100,      32'd7,        32'h00000002, 32'h0000000E, 10};
    vecs[5] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[6] = '{4'd3, 32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[7] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[8] = '{4'd4, 32'hFFFFFFFF, 32'h10,       32'h0000000F, 32'h0FFFFFFF, 10};

    reset = 1'b1; op = 4'd0; A = 32'd0; B = 32'd0;
    // start decode is purely combinational, so sweep every op while held in reset
    for (int o = 0; o < 16; o++) begin
      op = 4'(o);
      #1 check($sformatf("start_op%0d", o), {31'd0, start}, {31'd0, exp_start(4'(o))});
    end
    op = 4'd0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;

    for (int i = 0; i < 9; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, cyc, held);
      check($sformatf("v%0d_cycles", i), 32'(cyc), 32'(vecs[i].cyc));
      check($sformatf("v%0d_hold", i), {31'd0, held}, 32'd1);
      check($sformatf("v%0d_hi", i), HI, vecs[i].hi);
      check($sformatf("v%0d_lo", i), LO, vecs[i].lo);
    end

    // asynchronous reset in the middle of a divide
    @(negedge clk);
    op = 4'd3; A = 32'd100; B = 32'd7;
    @(posedge clk);
    #1 op = 4'd0;
    repeat (3) @(negedge clk);
    check("mid_busy_before", {31'd0, busy}, 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_hi", HI, 32'd0);
    check("mid_rst_lo", LO, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("post_rst_lo", LO, 32'd0);
    check("post_rst_hi", HI, 32'd0);
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    // mthi/mtlo take effect on their own edge, then divide by zero preserves them
    move_to(4'd5, 32'h12345678);
    check("mthi_hi", HI, 32'h12345678);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    move_to(4'd6, 32'h9);
    check("mtlo_lo", LO, 32'h9);
    check("mtlo_hi", HI, 32'h12345678);
    check("mtlo_busy", {31'd0, busy}, 32'd0);
    run_op(4'd4, 32'h10, 32'd0, cyc, held);
    check("dz_cycles", 32'(cyc), 32'd10);
    check("dz_hi", HI, 32'h12345678);
    check("dz_lo", LO, 32'h9);

    // ops during BUSY and on the completion edge are ignored
    move_to(4'd5, 32'd0);
    move_to(4'd6, 32'd0);
    @(negedge clk);
    op = 4'd1; A = 32'd2; B = 32'd3;
    @(posedge clk);
    #1 op = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      @(negedge clk);
      check($sformatf("ign_busy_c%0d", k), {31'd0, busy}, 32'd1);
      case (k)
        2: begin op = 4'd5; A = 32'hDEAD; end
        4: begin op = 4'd3; A = 32'd100; B = 32'd3; end
        5: begin op = 4'd1; A = 32'd9; B = 32'd9; end
        default: op = 4'd0;
      endcase
      if (k == 4) #1 check("start_while_busy", {31'd0, start}, 32'd1);
    end
    @(negedge clk);
    op = 4'd0;
    check("ign_busy_done", {31'd0, busy}, 32'd0);
    check("ign_hi", HI, 32'd0);
    check("ign_lo", LO, 32'd6);
    repeat (3) @(negedge clk);
    check("ign_no_retrigger", {31'd0, busy}, 32'd0);
    check("ign_lo_after", LO, 32'd6);

`ifdef MDU_MADD_EN
    move_to(4'd5, 32'd0);
    move_to(4'd6, 32'hFFFFFFFF);
    run_op(4'd8, 32'd1, 32'd1, cyc, held);
    check("maddu_cycles", 32'(cyc), 32'd5);
    check("maddu_hi", HI, 32'd1);
    check("maddu_lo", LO, 32'd0);
    move_to(4'd5, 32'd0);
    move_to(4'd6, 32'd0);
    run_op(4'd9, 32'd1, 32'd2, cyc, held);
    check("msub_cycles", 32'(cyc), 32'd5);
    check("msub_hi", HI, 32'hFFFFFFFF);
    check("msub_lo", LO, 32'hFFFFFFFE);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
